// File: rtl/collision_pkg.sv
// collision_pkg
//   Shared definitions for frame_collision_latch and its border detector:
//   default frame-size constants, border index enum, FSM state enum and the
//   helper that maps an object pair (i,j), i<j, onto its bit in the packed
//   upper-triangle pair vector.
package collision_pkg;

    localparam int PIX_W            = 11;
    localparam int X_FRAME_SIZE_DEF = 639;
    localparam int Y_FRAME_SIZE_DEF = 479;

    typedef enum logic [1:0] {
        B_LEFT   = 2'd0,
        B_RIGHT  = 2'd1,
        B_TOP    = 2'd2,
        B_BOTTOM = 2'd3
    } border_e;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } state_e;

    function automatic int num_pairs(input int n);
        return (n * (n - 1)) / 2;
    endfunction

    // Row-major walk of the strict upper triangle:
    // (0,1),(0,2)..(0,n-1),(1,2)..(n-2,n-1) -> 0,1,2,...
    function automatic int pair_idx(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/border_edge_detect.sv
// border_edge_detect
//   Purely combinational border-hit detection for one object channel.
//   Ports:
//     i_request  object covers the current pixel
//     i_pixel_x  current scan X (unsigned)
//     i_pixel_y  current scan Y (unsigned)
//     o_border   border hits this cycle, indexed by border_e
module border_edge_detect
    import collision_pkg::*;
#(
    parameter int X_FRAME_SIZE = X_FRAME_SIZE_DEF,
    parameter int Y_FRAME_SIZE = Y_FRAME_SIZE_DEF
) (
    input  logic             i_request,
    input  logic [PIX_W-1:0] i_pixel_x,
    input  logic [PIX_W-1:0] i_pixel_y,
    output logic [3:0]       o_border
);

    localparam logic [PIX_W-1:0] X_LAST = PIX_W'(X_FRAME_SIZE);
    localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(Y_FRAME_SIZE);

    // Exact equality: coordinates beyond the frame never count as a border.
    always_comb begin
        o_border           = '0;
        o_border[B_LEFT]   = i_request && (i_pixel_x == '0);
        o_border[B_RIGHT]  = i_request && (i_pixel_x == X_LAST);
        o_border[B_TOP]    = i_request && (i_pixel_y == '0);
        o_border[B_BOTTOM] = i_request && (i_pixel_y == Y_LAST);
    end

endmodule

// File: rtl/frame_collision_latch.sv
// frame_collision_latch
//   Accumulates border hits and object-pair overlaps over one frame and
//   presents them on registered outputs at the following startOfFrame. The
//   outputs hold for the whole next frame.
//   Ports:
//     clk, resetN        clock, async active-low reset
//     startOfFrame       one-cycle pulse on the first pixel of a frame
//     pixelX, pixelY     current scan position
//     drawingRequest     per-object coverage of the current pixel
//     hitLeft/Right/Top/Bottom  previous frame's border hits per object
//     objHit             previous frame's pair overlaps, full symmetric matrix
//     frameDone          one-cycle pulse when outputs update
//     anyHit             one-cycle pulse with frameDone when any bit is set
//
//   state    | meaning
//   WAIT_SOF | after reset; accumulators held clear, waiting for first SOF
//   RUN      | accumulating; every SOF transfers and restarts the frame
module frame_collision_latch
    import collision_pkg::*;
#(
    parameter int                     N_OBJ        = 4,
    parameter int                     X_FRAME_SIZE = X_FRAME_SIZE_DEF,
    parameter int                     Y_FRAME_SIZE = Y_FRAME_SIZE_DEF,
    parameter logic [N_OBJ*N_OBJ-1:0] PAIR_MASK    = '1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [PIX_W-1:0]         pixelX,
    input  logic [PIX_W-1:0]         pixelY,
    input  logic [N_OBJ-1:0]         drawingRequest,
    output logic [N_OBJ-1:0]         hitLeft,
    output logic [N_OBJ-1:0]         hitRight,
    output logic [N_OBJ-1:0]         hitTop,
    output logic [N_OBJ-1:0]         hitBottom,
    output logic [N_OBJ*N_OBJ-1:0]   objHit,
    output logic                     frameDone,
    output logic                     anyHit
);

    localparam int N_PAIR = num_pairs(N_OBJ);

    logic [3:0]              w_border [N_OBJ];
    logic [N_OBJ-1:0]        w_det_left;
    logic [N_OBJ-1:0]        w_det_right;
    logic [N_OBJ-1:0]        w_det_top;
    logic [N_OBJ-1:0]        w_det_bottom;
    logic [N_PAIR-1:0]       w_det_pair;
    logic [N_OBJ*N_OBJ-1:0]  w_pair_full;

    logic [N_OBJ-1:0]        r_acc_left;
    logic [N_OBJ-1:0]        r_acc_right;
    logic [N_OBJ-1:0]        r_acc_top;
    logic [N_OBJ-1:0]        r_acc_bottom;
    logic [N_PAIR-1:0]       r_acc_pair;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic                    w_acc_en;
    logic                    w_transfer;

    for (genvar g = 0; g < N_OBJ; g++) begin : g_border
        border_edge_detect #(
            .X_FRAME_SIZE (X_FRAME_SIZE),
            .Y_FRAME_SIZE (Y_FRAME_SIZE)
        ) u_border (
            .i_request (drawingRequest[g]),
            .i_pixel_x (pixelX),
            .i_pixel_y (pixelY),
            .o_border  (w_border[g])
        );
    end

    always_comb begin
        w_det_left   = '0;
        w_det_right  = '0;
        w_det_top    = '0;
        w_det_bottom = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            w_det_left[k]   = w_border[k][B_LEFT];
            w_det_right[k]  = w_border[k][B_RIGHT];
            w_det_top[k]    = w_border[k][B_TOP];
            w_det_bottom[k] = w_border[k][B_BOTTOM];
        end
    end

    // Only the upper triangle of PAIR_MASK is consulted.
    always_comb begin
        w_det_pair = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            for (int j = i + 1; j < N_OBJ; j++) begin
                w_det_pair[pair_idx(i, j, N_OBJ)] = drawingRequest[i]
                    & drawingRequest[j] & PAIR_MASK[i*N_OBJ+j];
            end
        end
    end

    // Expand the triangle into the symmetric matrix; diagonal stays 0.
    always_comb begin
        w_pair_full = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            for (int j = 0; j < N_OBJ; j++) begin
                if (i < j) begin
                    w_pair_full[i*N_OBJ+j] = r_acc_pair[pair_idx(i, j, N_OBJ)];
                end else if (i > j) begin
                    w_pair_full[i*N_OBJ+j] = r_acc_pair[pair_idx(j, i, N_OBJ)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_en    = 1'b0;
        w_transfer  = 1'b0;
        case (r_state)
            WAIT_SOF: begin
                if (startOfFrame) begin
                    w_state_nxt = RUN;
                    w_acc_en    = 1'b1;
                end
            end
            RUN: begin
                w_acc_en   = 1'b1;
                w_transfer = startOfFrame;
            end
            default: begin
                w_state_nxt = WAIT_SOF;
            end
        endcase
    end

    // On an SOF cycle the accumulators drop the old frame and take only this
    // cycle's detections, so the first pixel lands in the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_acc_left   <= '0;
            r_acc_right  <= '0;
            r_acc_top    <= '0;
            r_acc_bottom <= '0;
            r_acc_pair   <= '0;
        end else if (!w_acc_en) begin
            r_acc_left   <= '0;
            r_acc_right  <= '0;
            r_acc_top    <= '0;
            r_acc_bottom <= '0;
            r_acc_pair   <= '0;
        end else if (startOfFrame) begin
            r_acc_left   <= w_det_left;
            r_acc_right  <= w_det_right;
            r_acc_top    <= w_det_top;
            r_acc_bottom <= w_det_bottom;
            r_acc_pair   <= w_det_pair;
        end else begin
            r_acc_left   <= r_acc_left   | w_det_left;
            r_acc_right  <= r_acc_right  | w_det_right;
            r_acc_top    <= r_acc_top    | w_det_top;
            r_acc_bottom <= r_acc_bottom | w_det_bottom;
            r_acc_pair   <= r_acc_pair   | w_det_pair;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hitLeft   <= '0;
            hitRight  <= '0;
            hitTop    <= '0;
            hitBottom <= '0;
            objHit    <= '0;
            frameDone <= 1'b0;
            anyHit    <= 1'b0;
        end else if (w_transfer) begin
            hitLeft   <= r_acc_left;
            hitRight  <= r_acc_right;
            hitTop    <= r_acc_top;
            hitBottom <= r_acc_bottom;
            objHit    <= w_pair_full;
            frameDone <= 1'b1;
            anyHit    <= |{r_acc_left, r_acc_right, r_acc_top, r_acc_bottom,
                           r_acc_pair};
        end else begin
            frameDone <= 1'b0;
            anyHit    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_frame_collision_latch.sv
module tb_frame_collision_latch;

    localparam int          N       = 4;
    localparam int          XL      = 639;
    localparam int          YL      = 479;
    localparam logic [15:0] MASK_M  = 16'hFFF7;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;
    logic [3:0]  req = '0;

    logic [3:0]  hl, hr, ht, hb;
    logic [15:0] oh;
    logic        fd, ah;
    logic [3:0]  hl_m, hr_m, ht_m, hb_m;
    logic [15:0] oh_m;
    logic        fd_m, ah_m;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    frame_collision_latch #(.N_OBJ(N), .X_FRAME_SIZE(XL), .Y_FRAME_SIZE(YL)) u_dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .drawingRequest(req), .hitLeft(hl), .hitRight(hr), .hitTop(ht),
        .hitBottom(hb), .objHit(oh), .frameDone(fd), .anyHit(ah));

    frame_collision_latch #(.N_OBJ(N), .X_FRAME_SIZE(XL), .Y_FRAME_SIZE(YL),
                            .PAIR_MASK(MASK_M)) u_dut_m (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .pixelX(px), .pixelY(py),
        .drawingRequest(req), .hitLeft(hl_m), .hitRight(hr_m), .hitTop(ht_m),
        .hitBottom(hb_m), .objHit(oh_m), .frameDone(fd_m), .anyHit(ah_m));

    // Reference model: per-frame event sets as bit arrays.
    // Border index 0..3 = left,right,top,bottom.
    bit m_run;
    bit acc_b [4][N];  bit out_b [4][N];
    bit acc_p [N][N];  bit out_p [N][N];
    bit acc_q [N][N];  bit out_q [N][N];
    bit m_fd, m_any, m_any_q;

    task automatic model_clear();
        m_run = 0; m_fd = 0; m_any = 0; m_any_q = 0;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < N; k++) begin acc_b[b][k] = 0; out_b[b][k] = 0; end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc_p[i][j] = 0; out_p[i][j] = 0; acc_q[i][j] = 0; out_q[i][j] = 0;
            end
    endtask

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            model_clear();
        end else begin
            bit db [4][N];
            bit dp [N][N];
            bit dq [N][N];
            bit bor;
            for (int k = 0; k < N; k++) begin
                db[0][k] = req[k] && (px == 0);
                db[1][k] = req[k] && (int'(px) == XL);
                db[2][k] = req[k] && (py == 0);
                db[3][k] = req[k] && (int'(py) == YL);
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    dp[i][j] = (i != j) && req[i] && req[j];
                    dq[i][j] = dp[i][j] && !((i == 0 && j == 3) || (i == 3 && j == 0));
                end
            m_fd = 0; m_any = 0; m_any_q = 0;
            if (m_run && sof) begin
                bor = 0;
                for (int b = 0; b < 4; b++)
                    for (int k = 0; k < N; k++) begin
                        out_b[b][k] = acc_b[b][k]; bor |= acc_b[b][k];
                    end
                m_any = bor; m_any_q = bor;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        out_p[i][j] = acc_p[i][j]; out_q[i][j] = acc_q[i][j];
                        m_any   |= acc_p[i][j];
                        m_any_q |= acc_q[i][j];
                    end
                m_fd = 1;
            end
            if (sof || m_run) begin
                for (int b = 0; b < 4; b++)
                    for (int k = 0; k < N; k++)
                        acc_b[b][k] = sof ? db[b][k] : (acc_b[b][k] | db[b][k]);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        acc_p[i][j] = sof ? dp[i][j] : (acc_p[i][j] | dp[i][j]);
                        acc_q[i][j] = sof ? dq[i][j] : (acc_q[i][j] | dq[i][j]);
                    end
            end
            if (sof) m_run = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  el, er, et, eb;
            logic [15:0] ep, eq;
            for (int k = 0; k < N; k++) begin
                el[k] = out_b[0][k]; er[k] = out_b[1][k];
                et[k] = out_b[2][k]; eb[k] = out_b[3][k];
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ep[i*N+j] = out_p[i][j]; eq[i*N+j] = out_q[i][j];
                end
            check("hitLeft", 32'(hl), 32'(el));
            check("hitRight", 32'(hr), 32'(er));
            check("hitTop", 32'(ht), 32'(et));
            check("hitBottom", 32'(hb), 32'(eb));
            check("objHit", 32'(oh), 32'(ep));
            check("frameDone", 32'(fd), 32'(m_fd));
            check("anyHit", 32'(ah), 32'(m_any));
            check("objHit_masked", 32'(oh_m), 32'(eq));
            check("hitLeft_masked", 32'(hl_m), 32'(el));
            check("frameDone_masked", 32'(fd_m), 32'(m_fd));
            check("anyHit_masked", 32'(ah_m), 32'(m_any_q));
        end
    end

    task automatic cyc(input bit s, input logic [3:0] r, input int x, input int y);
        sof = s; req = r; px = 11'(x); py = 11'(y);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 6))
            0: return 0;
            1: return XL;
            2: return 700;
            3: return 1;
            4: return XL - 1;
            5: return 2047;
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    function automatic int rand_y();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return YL;
            2: return YL + 1;
            3: return 2047;
            default: return int'($urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset_hitLeft", 32'(hl), 32'h0);
        check("reset_objHit", 32'(oh), 32'h0);
        resetN = 1'b1;
        cyc(0, 4'b0000, 5, 5);

        // First SOF: no frameDone; empty frame reports anyHit=0.
        cyc(1, 4'b0000, 0, 0);
        check("first_sof_frameDone", 32'(fd), 32'h0);
        repeat (10) cyc(0, 4'b0000, 10, 10);
        cyc(1, 4'b0000, 0, 0);
        check("second_sof_frameDone", 32'(fd), 32'h1);
        check("second_sof_anyHit", 32'(ah), 32'h0);

        // Object 2 at (0,100) and (639,479).
        cyc(0, 4'b0100, 0, 100);
        cyc(0, 4'b0100, 639, 479);
        repeat (3) cyc(0, 4'b0000, 50, 50);
        cyc(1, 4'b0000, 5, 5);
        check("border_left", 32'(hl), 32'h4);
        check("border_right", 32'(hr), 32'h4);
        check("border_bottom", 32'(hb), 32'h4);
        check("border_top", 32'(ht), 32'h0);
        check("border_anyHit", 32'(ah), 32'h1);
        repeat (8) cyc(0, 4'b0000, 60, 60);
        check("border_hold_left", 32'(hl), 32'h4);
        check("border_hold_frameDone", 32'(fd), 32'h0);
        cyc(1, 4'b0000, 5, 5);
        check("border_cleared", 32'(hl), 32'h0);

        // Pair (0,3) with and without its mask bit.
        cyc(0, 4'b1001, 320, 240);
        cyc(1, 4'b0000, 5, 5);
        check("pair_objHit", 32'(oh), 32'h1008);
        check("pair_objHit_masked", 32'(oh_m), 32'h0);
        check("pair_anyHit_masked", 32'(ah_m), 32'h0);

        // Request at (0,0) on the SOF cycle belongs to the new frame
        // (back-to-back SOF).
        cyc(1, 4'b0010, 0, 0);
        check("sof_same_cycle_left", 32'(hl), 32'h0);
        check("sof_same_cycle_frameDone", 32'(fd), 32'h1);
        repeat (4) cyc(0, 4'b0000, 30, 30);
        cyc(1, 4'b0000, 5, 5);
        check("sof_next_left", 32'(hl), 32'h2);
        check("sof_next_top", 32'(ht), 32'h2);

        // Mid-frame reset.
        cyc(0, 4'b0001, 0, 50);
        cyc(1, 4'b0000, 5, 5);
        check("pre_reset_left", 32'(hl), 32'h1);
        cyc(0, 4'b0001, 0, 0);
        #2 resetN = 1'b0;
        #1;
        check("reset_mid_left", 32'(hl), 32'h0);
        check("reset_mid_top", 32'(ht), 32'h0);
        cyc(0, 4'b0000, 5, 5);
        cyc(0, 4'b0000, 5, 5);
        resetN = 1'b1;
        cyc(0, 4'b0001, 0, 0);
        cyc(1, 4'b0000, 5, 5);
        check("reset_first_sof_frameDone", 32'(fd), 32'h0);
        cyc(0, 4'b0001, 0, 9);
        cyc(1, 4'b0000, 5, 5);
        check("reset_resume_frameDone", 32'(fd), 32'h1);
        check("reset_resume_left", 32'(hl), 32'h1);

        // Coordinates above the frame never match.
        cyc(0, 4'b0001, 700, 5);
        cyc(0, 4'b0001, 2047, 2047);
        cyc(0, 4'b0001, 640, 480);
        cyc(1, 4'b0000, 5, 5);
        check("oob_right", 32'(hr), 32'h0);
        check("oob_bottom", 32'(hb), 32'h0);

        // Randomised frames, including back-to-back SOF and occasional reset.
        for (int f = 0; f < 80; f++) begin
            int len;
            len = int'($urandom_range(0, 25));
            for (int c = 0; c < len; c++) begin
                logic [3:0] r;
                r = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3))
                                                : 4'($urandom_range(0, 15));
                cyc(0, r, rand_x(), rand_y());
                if ($urandom_range(0, 300) == 0) begin
                    #2 resetN = 1'b0;
                    #3 resetN = 1'b1;
                end
            end
            cyc(1, 4'($urandom_range(0, 15)), rand_x(), rand_y());
        end
        repeat (3) cyc(0, 4'b0000, 5, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
